// File: rtl/mcs8_sysctl_if.sv
// Bus bundle between the 8008-style CPU, the system controller and the memory/I-O side.
// The slave modport is the controller; the master modport is the CPU and memory environment.
interface mcs8_sysctl_if;
    logic        SYNC_I;
    logic [2:0]  STATE_I;
    logic [7:0]  DAT_I;
    logic [7:0]  DAT_O;
    logic        DAT_OE_O;
    logic        READY_O;
    logic        INT_O;
    logic        IRQ_I;
    logic [13:0] MEM_ADDR_O;
    logic [7:0]  MEM_DAT_O;
    logic [7:0]  MEM_DAT_I;
    logic        MEM_RD_O;
    logic        MEM_WR_O;
    logic        IO_RD_O;
    logic        IO_WR_O;
    logic        MEM_ACK_I;
    logic        BUS_ERR_O;

    modport slave (
        input  SYNC_I, STATE_I, DAT_I, IRQ_I, MEM_DAT_I, MEM_ACK_I,
        output DAT_O, DAT_OE_O, READY_O, INT_O, MEM_ADDR_O, MEM_DAT_O,
        output MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O, BUS_ERR_O
    );

    modport master (
        output SYNC_I, STATE_I, DAT_I, IRQ_I, MEM_DAT_I, MEM_ACK_I,
        input  DAT_O, DAT_OE_O, READY_O, INT_O, MEM_ADDR_O, MEM_DAT_O,
        input  MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O, BUS_ERR_O
    );
endinterface

// File: rtl/mcs8_sysctl.sv
// System-side responder for the 8008-style T-state/SYNC bus: decodes T1/T2 bytes, runs a
// request/ack transaction to memory or I/O, returns read data at T3 and jams RST on T1I.
module mcs8_sysctl #(
    parameter logic [2:0]  INT_VEC  = 3'b000,
    parameter int unsigned WAIT_MAX = 16
) (
    input logic          CLK1_I,
    input logic          nRST_I,
    mcs8_sysctl_if.slave bus
);
    localparam logic [2:0] TsT1   = 3'b010;
    localparam logic [2:0] TsT1i  = 3'b110;
    localparam logic [2:0] TsT2   = 3'b100;
    localparam logic [2:0] TsWait = 3'b000;
    localparam logic [2:0] TsT3   = 3'b001;
    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {StIdle, StWdat, StWack, StHave} state_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_l_q, addr_l_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic        pend_q, pend_d;
    logic        jam_q, jam_d;
    logic        ready_q, ready_d;
    logic        int_q, int_d;
    logic        err_q, err_d;
    logic        is_rd_q, is_rd_d;
    logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic        io_rd_q, io_rd_d, io_wr_q, io_wr_d;

    logic        sample, timeout, done, t2_go;
    logic [7:0]  t2_byte;

    assign sample = bus.SYNC_I;

    always_comb begin
        state_d     = state_q;
        addr_l_d    = addr_l_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        wdat_d      = wdat_q;
        cnt_d       = cnt_q;
        pend_byte_d = pend_byte_q;
        pend_d      = pend_q;
        jam_d       = jam_q;
        ready_d     = ready_q;
        int_d       = int_q;
        err_d       = 1'b0;
        is_rd_d     = is_rd_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        io_rd_d     = io_rd_q;
        io_wr_d     = io_wr_q;
        timeout     = 1'b0;
        done        = 1'b0;
        t2_go       = 1'b0;
        t2_byte     = bus.DAT_I;

        if (sample && bus.STATE_I == TsT1i) begin
            int_d = 1'b0;
        end else if (bus.IRQ_I && !jam_q) begin
            int_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (sample && bus.STATE_I == TsT2) t2_go = 1'b1;
            end
            StWdat: begin
                if (sample && bus.STATE_I == TsT3) begin
                    wdat_d   = bus.DAT_I;
                    mem_wr_d = 1'b1;
                    is_rd_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = StWack;
                end
            end
            StWack: begin
                timeout = (cnt_q == WaitLast);
                done    = bus.MEM_ACK_I || timeout;
                cnt_d   = cnt_q + 8'd1;
                if (done) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    io_rd_d  = 1'b0;
                    io_wr_d  = 1'b0;
                    ready_d  = 1'b1;
                    // Ack wins over a coincident timeout
                    err_d    = !bus.MEM_ACK_I;
                    if (is_rd_q) begin
                        rdata_d = bus.MEM_ACK_I ? bus.MEM_DAT_I : 8'hFF;
                        state_d = StHave;
                    end else if (pend_q) begin
                        t2_go   = 1'b1;
                        t2_byte = pend_byte_q;
                        pend_d  = 1'b0;
                    end else if (sample && bus.STATE_I == TsT2) begin
                        t2_go = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (sample && bus.STATE_I == TsT2 && !is_rd_q && !pend_q) begin
                    // Cycle arriving behind a write: stall the CPU and replay its T2 byte later
                    pend_d      = 1'b1;
                    pend_byte_d = bus.DAT_I;
                    ready_d     = 1'b0;
                end
            end
            StHave: begin
                if (!(bus.STATE_I inside {TsT2, TsWait, TsT3})) begin
                    state_d = StIdle;
                    jam_d   = 1'b0;
                end
            end
        endcase

        if (t2_go) begin
            cnt_d  = '0;
            addr_d = {t2_byte[5:0], addr_l_q};
            unique case (t2_byte[7:6])
                2'b00, 2'b10: begin
                    if (jam_q) begin
                        rdata_d = {2'b00, INT_VEC, 3'b101};
                        ready_d = 1'b1;
                        state_d = StHave;
                    end else begin
                        mem_rd_d = 1'b1;
                        is_rd_d  = 1'b1;
                        ready_d  = 1'b0;
                        state_d  = StWack;
                    end
                end
                2'b01: begin
                    addr_d  = {9'd0, t2_byte[5:1]};
                    state_d = StWack;
                    if (t2_byte[5:4] == 2'b00) begin
                        io_rd_d = 1'b1;
                        is_rd_d = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        io_wr_d = 1'b1;
                        is_rd_d = 1'b0;
                        wdat_d  = addr_l_q;
                        ready_d = 1'b1;
                    end
                end
                2'b11: begin
                    ready_d = 1'b1;
                    state_d = StWdat;
                end
            endcase
        end

        if (sample && (bus.STATE_I == TsT1 || bus.STATE_I == TsT1i)) begin
            addr_l_d = bus.DAT_I;
            jam_d    = (bus.STATE_I == TsT1i);
        end
    end

    always_ff @(posedge CLK1_I) begin
        if (!nRST_I) begin
            state_q     <= StIdle;
            addr_l_q    <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            wdat_q      <= '0;
            cnt_q       <= '0;
            pend_byte_q <= '0;
            pend_q      <= 1'b0;
            jam_q       <= 1'b0;
            ready_q     <= 1'b1;
            int_q       <= 1'b0;
            err_q       <= 1'b0;
            is_rd_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_l_q    <= addr_l_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            wdat_q      <= wdat_d;
            cnt_q       <= cnt_d;
            pend_byte_q <= pend_byte_d;
            pend_q      <= pend_d;
            jam_q       <= jam_d;
            ready_q     <= ready_d;
            int_q       <= int_d;
            err_q       <= err_d;
            is_rd_q     <= is_rd_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            io_rd_q     <= io_rd_d;
            io_wr_q     <= io_wr_d;
        end
    end

    assign bus.DAT_OE_O   = (state_q == StHave) && (bus.STATE_I == TsT3);
    assign bus.DAT_O      = bus.DAT_OE_O ? rdata_q : 8'h00;
    assign bus.READY_O    = ready_q;
    assign bus.INT_O      = int_q;
    assign bus.MEM_ADDR_O = addr_q;
    assign bus.MEM_DAT_O  = wdat_q;
    assign bus.MEM_RD_O   = mem_rd_q;
    assign bus.MEM_WR_O   = mem_wr_q;
    assign bus.IO_RD_O    = io_rd_q;
    assign bus.IO_WR_O    = io_wr_q;
    assign bus.BUS_ERR_O  = err_q;
endmodule

// File: tb/tb_mcs8_sysctl.sv
// Directed bench for mcs8_sysctl: a clocked vector table for read/IN/OUT cycles plus
// hand sequences for write queuing, interrupt jam, timeout and mid-transaction reset.
module tb_mcs8_sysctl;
    localparam logic [2:0] T1 = 3'b010, T1I = 3'b110, T2 = 3'b100, TW = 3'b000;
    localparam logic [2:0] T3 = 3'b001, T4 = 3'b111, T5 = 3'b101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mcs8_sysctl_if bus_if ();

    mcs8_sysctl #(
        .INT_VEC (3'b011),
        .WAIT_MAX(16)
    ) dut (
        .CLK1_I(clk),
        .nRST_I(rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic        sync;
        logic [2:0]  st;
        logic [7:0]  dat;
        logic        ack;
        logic [7:0]  mdat;
        logic        ready;
        logic        mrd;
        logic        iord;
        logic        iowr;
        logic        oe;
        logic [7:0]  dato;
        logic [13:0] addr;
        logic [7:0]  mdato;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic s, input logic [2:0] st, input logic [7:0] d,
                               input logic a, input logic [7:0] md, input logic rdy,
                               input logic mrd, input logic iord, input logic iowr,
                               input logic oe, input logic [7:0] dato, input logic [13:0] addr,
                               input logic [7:0] mdato);
        vec_t r;
        r.sync = s; r.st = st; r.dat = d; r.ack = a; r.mdat = md; r.ready = rdy;
        r.mrd = mrd; r.iord = iord; r.iowr = iowr; r.oe = oe; r.dato = dato;
        r.addr = addr; r.mdato = mdato;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic s, input logic [2:0] st, input logic [7:0] d);
        bus_if.SYNC_I  = s;
        bus_if.STATE_I = st;
        bus_if.DAT_I   = d;
        tick();
    endtask

    initial begin
        int n;
        int errs;

        bus_if.SYNC_I = 1'b0; bus_if.STATE_I = T1; bus_if.DAT_I = 8'h00;
        bus_if.IRQ_I = 1'b0; bus_if.MEM_ACK_I = 1'b0; bus_if.MEM_DAT_I = 8'h00;

        // PCI read of 0123 acked after 3 clocks, then OUT port 9 and IN port 2
        vq.push_back(v(1, T1, 8'h23, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 14'h0000, 8'h00));
        vq.push_back(v(0, T1, 8'h23, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 14'h0000, 8'h00));
        vq.push_back(v(1, T2, 8'h01, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 14'h0123, 8'h00));
        vq.push_back(v(0, TW, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 14'h0123, 8'h00));
        vq.push_back(v(1, TW, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 14'h0123, 8'h00));
        vq.push_back(v(0, TW, 8'h00, 1, 8'h3E, 1, 0, 0, 0, 0, 8'h00, 14'h0123, 8'h00));
        vq.push_back(v(1, T3, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'h3E, 14'h0123, 8'h00));
        vq.push_back(v(0, T3, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'h3E, 14'h0123, 8'h00));
        vq.push_back(v(1, T4, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 14'h0123, 8'h00));
        vq.push_back(v(1, T1, 8'hC3, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 14'h0123, 8'h00));
        vq.push_back(v(1, T2, 8'h52, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 14'h0009, 8'hC3));
        vq.push_back(v(1, T3, 8'h00, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 14'h0009, 8'hC3));
        vq.push_back(v(1, T1, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 14'h0009, 8'hC3));
        vq.push_back(v(1, T2, 8'h44, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 14'h0002, 8'hC3));
        vq.push_back(v(1, TW, 8'h00, 1, 8'h5A, 1, 0, 0, 0, 0, 8'h00, 14'h0002, 8'hC3));
        vq.push_back(v(1, T3, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'h5A, 14'h0002, 8'hC3));
        vq.push_back(v(1, T4, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 14'h0002, 8'hC3));

        tick(); tick();
        chk("rst ready", bus_if.READY_O, 1);
        chk("rst reqs", {bus_if.MEM_RD_O, bus_if.MEM_WR_O, bus_if.IO_RD_O, bus_if.IO_WR_O}, 0);
        chk("rst addr", bus_if.MEM_ADDR_O, 0);
        chk("rst int/err/oe", {bus_if.INT_O, bus_if.BUS_ERR_O, bus_if.DAT_OE_O}, 0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            bus_if.MEM_ACK_I = vq[i].ack;
            bus_if.MEM_DAT_I = vq[i].mdat;
            cyc(vq[i].sync, vq[i].st, vq[i].dat);
            chk($sformatf("v%0d ready", i), bus_if.READY_O, vq[i].ready);
            chk($sformatf("v%0d mem_rd", i), bus_if.MEM_RD_O, vq[i].mrd);
            chk($sformatf("v%0d io_rd", i), bus_if.IO_RD_O, vq[i].iord);
            chk($sformatf("v%0d io_wr", i), bus_if.IO_WR_O, vq[i].iowr);
            chk($sformatf("v%0d mem_wr", i), bus_if.MEM_WR_O, 0);
            chk($sformatf("v%0d oe", i), bus_if.DAT_OE_O, vq[i].oe);
            chk($sformatf("v%0d dat_o", i), bus_if.DAT_O, vq[i].dato);
            chk($sformatf("v%0d addr", i), bus_if.MEM_ADDR_O, vq[i].addr);
            chk($sformatf("v%0d mem_dat_o", i), bus_if.MEM_DAT_O, vq[i].mdato);
        end
        bus_if.MEM_ACK_I = 1'b0;

        // PCW 2A55 <- 77, with a PCR of 0001 queued behind it
        cyc(1, T1, 8'h55);
        cyc(1, T2, 8'hEA);
        chk("pcw t2 ready", bus_if.READY_O, 1);
        chk("pcw t2 wr", bus_if.MEM_WR_O, 0);
        cyc(1, T3, 8'h77);
        chk("pcw wr", bus_if.MEM_WR_O, 1);
        chk("pcw data", bus_if.MEM_DAT_O, 8'h77);
        chk("pcw addr", bus_if.MEM_ADDR_O, 14'h2A55);
        chk("pcw ready", bus_if.READY_O, 1);
        cyc(0, T3, 8'h77);
        cyc(1, T4, 8'h00);
        cyc(1, T5, 8'h00);
        chk("pcw ready late", bus_if.READY_O, 1);
        cyc(1, T1, 8'h01);
        chk("b2b t1 addr", bus_if.MEM_ADDR_O, 14'h2A55);
        chk("b2b t1 wr", bus_if.MEM_WR_O, 1);
        cyc(1, T2, 8'h80);
        chk("b2b t2 ready", bus_if.READY_O, 0);
        chk("b2b t2 rd", bus_if.MEM_RD_O, 0);
        chk("b2b t2 wr", bus_if.MEM_WR_O, 1);
        bus_if.MEM_ACK_I = 1'b1;
        cyc(1, TW, 8'h00);
        bus_if.MEM_ACK_I = 1'b0;
        chk("b2b wr done", bus_if.MEM_WR_O, 0);
        chk("b2b rd issued", bus_if.MEM_RD_O, 1);
        chk("b2b rd addr", bus_if.MEM_ADDR_O, 14'h0001);
        chk("b2b ready", bus_if.READY_O, 0);
        cyc(0, TW, 8'h00);
        chk("b2b rd held", bus_if.MEM_RD_O, 1);
        bus_if.MEM_ACK_I = 1'b1; bus_if.MEM_DAT_I = 8'h99;
        cyc(1, TW, 8'h00);
        bus_if.MEM_ACK_I = 1'b0;
        chk("b2b rd done", bus_if.MEM_RD_O, 0);
        chk("b2b ready up", bus_if.READY_O, 1);
        cyc(1, T3, 8'h00);
        chk("b2b t3 data", {bus_if.DAT_OE_O, bus_if.DAT_O}, {1'b1, 8'h99});
        cyc(1, T4, 8'h00);
        chk("b2b t4 oe", bus_if.DAT_OE_O, 0);

        // Interrupt and jammed RST 3 (8'h1D)
        bus_if.IRQ_I = 1'b1;
        cyc(0, T4, 8'h00);
        chk("irq int", bus_if.INT_O, 1);
        bus_if.IRQ_I = 1'b0;
        cyc(0, T4, 8'h00);
        chk("irq int held", bus_if.INT_O, 1);
        cyc(1, T1I, 8'h00);
        chk("t1i int clr", bus_if.INT_O, 0);
        cyc(1, T2, 8'h00);
        chk("jam rd", bus_if.MEM_RD_O, 0);
        chk("jam ready", bus_if.READY_O, 1);
        bus_if.IRQ_I = 1'b1;
        cyc(1, T3, 8'h00);
        chk("jam data", {bus_if.DAT_OE_O, bus_if.DAT_O}, {1'b1, 8'h1D});
        chk("jam int masked", bus_if.INT_O, 0);
        cyc(0, T3, 8'h00);
        chk("jam data held", bus_if.DAT_O, 8'h1D);
        cyc(1, T4, 8'h00);
        cyc(0, T4, 8'h00);
        chk("irq rearm", bus_if.INT_O, 1);
        bus_if.IRQ_I = 1'b0;
        cyc(1, T1I, 8'h00);
        chk("rearm clr", bus_if.INT_O, 0);

        // Read with no ack times out after 16 clocks
        cyc(1, T1, 8'h10);
        cyc(1, T2, 8'h00);
        chk("to rd start", bus_if.MEM_RD_O, 1);
        chk("to addr", bus_if.MEM_ADDR_O, 14'h0010);
        n = 0;
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(0, TW, 8'h00);
            if (bus_if.BUS_ERR_O) errs++;
            if (!bus_if.MEM_RD_O) break;
            n++;
        end
        chk("to rd clocks", n + 1, 16);
        chk("to ready", bus_if.READY_O, 1);
        cyc(1, T3, 8'h00);
        if (bus_if.BUS_ERR_O) errs++;
        chk("to err pulses", errs, 1);
        chk("to data", {bus_if.DAT_OE_O, bus_if.DAT_O}, {1'b1, 8'hFF});
        cyc(1, T4, 8'h00);

        // Reset while waiting on an ack
        cyc(1, T1, 8'h00);
        cyc(1, T2, 8'h00);
        cyc(0, TW, 8'h00);
        chk("rst pre rd", bus_if.MEM_RD_O, 1);
        rst_n = 1'b0;
        cyc(0, T3, 8'h00);
        chk("mid rst reqs", {bus_if.MEM_RD_O, bus_if.MEM_WR_O, bus_if.IO_RD_O, bus_if.IO_WR_O}, 0);
        chk("mid rst ready", bus_if.READY_O, 1);
        chk("mid rst oe", bus_if.DAT_OE_O, 0);
        rst_n = 1'b1;
        cyc(1, T3, 8'h00);
        chk("post rst idle", {bus_if.DAT_OE_O, bus_if.MEM_RD_O, bus_if.READY_O}, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
